// File: rtl/joy_socd_cond.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : joy_socd_cond                                           |
// | Desc   : Joystick direction conditioner. Per-bit 2-flop sync,    |
// |          optional debounce, SOCD resolution on each opposing     |
// |          pair, optional 4-way diagonal suppression, registered   |
// |          output.                                                 |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module joy_socd_cond #(
    parameter int PLAYERS    = 2,
    parameter int DEB_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 I_RESETn,
    input  logic [4*PLAYERS-1:0] indir,
    input  logic [1:0]           socd_mode,
    input  logic [PLAYERS-1:0]   four_way,
    output logic [4*PLAYERS-1:0] outdir
);

    localparam int   C_NBITS  = 4 * PLAYERS;
    localparam logic C_AXIS_H = 1'b0;
    localparam logic C_AXIS_V = 1'b1;

    logic [C_NBITS-1:0] sync1_q, sync1_d;
    logic [C_NBITS-1:0] sync2_q, sync2_d;
    logic [C_NBITS-1:0] deb;
    logic [C_NBITS-1:0] deb_prev_q, deb_prev_d;
    logic [C_NBITS-1:0] press;

    // Resolve one opposing pair {a,b} where a is L (or U) and wins all ties.
    // hist: 10 = a pressed last, 01 = b pressed last, 11 = both together, 00 = none.
    function automatic logic [1:0] resolve_pair(input logic [1:0] held,
                                                input logic [1:0] hist,
                                                input logic [1:0] mode);
        logic [1:0] res;
        res = held;
        if (held == 2'b11) begin
            if (mode[0])            res = 2'b00;
            else if (hist == 2'b11) res = 2'b10;
            else if (hist == 2'b10) res = mode[1] ? 2'b01 : 2'b10;
            else if (hist == 2'b01) res = mode[1] ? 2'b10 : 2'b01;
            else                    res = 2'b00;
        end
        return res;
    endfunction

    // Next state of the synchroniser chain and of the previous debounced value
    always_comb begin
        sync1_d    = indir;
        sync2_d    = sync1_q;
        deb_prev_d = deb;
    end

    // Synchroniser and press-edge reference registers
    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_prev_q <= deb_prev_d;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_deb_bypass
            assign deb = sync2_q;
        end else begin : g_deb_count
            localparam logic [7:0] C_DEB_LAST = 8'(DEB_CYCLES - 1);

            logic [C_NBITS-1:0]      deb_q, deb_d;
            logic [C_NBITS-1:0][7:0] cnt_q, cnt_d;

            // Each bit only follows the sync value after DEB_CYCLES consecutive disagreeing edges
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                for (int i = 0; i < C_NBITS; i++) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (cnt_q[i] == C_DEB_LAST) deb_d[i] = sync2_q[i];
                        else                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
            end

            // Debounced value and stability counters
            always_ff @(posedge clk or negedge I_RESETn) begin
                if (!I_RESETn) begin
                    deb_q <= '0;
                    cnt_q <= '0;
                end else begin
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    assign press = deb & ~deb_prev_q;

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_player
            logic [3:0] held, pr, res;
            logic [3:0] out_q, out_d;
            logic [1:0] last_h_q, last_h_d;
            logic [1:0] last_v_q, last_v_d;
            logic       axis_q, axis_d;

            assign held = deb[4*p +: 4];
            assign pr   = press[4*p +: 4];

            // History and axis follow presses in the same cycle they occur, then resolve
            always_comb begin
                last_h_d = last_h_q;
                last_v_d = last_v_q;
                axis_d   = axis_q;
                if (pr[1] | pr[0]) last_h_d = pr[1:0];
                if (pr[3] | pr[2]) last_v_d = pr[3:2];
                if (pr[1] | pr[0])      axis_d = C_AXIS_H;
                else if (pr[3] | pr[2]) axis_d = C_AXIS_V;
                res   = {resolve_pair(held[3:2], last_v_d, socd_mode),
                         resolve_pair(held[1:0], last_h_d, socd_mode)};
                out_d = res;
                if (four_way[p] && (|res[1:0]) && (|res[3:2]))
                    out_d = (axis_d == C_AXIS_V) ? {res[3:2], 2'b00} : {2'b00, res[1:0]};
            end

            // Per-player history, axis and output registers
            always_ff @(posedge clk or negedge I_RESETn) begin
                if (!I_RESETn) begin
                    last_h_q <= 2'b00;
                    last_v_q <= 2'b00;
                    axis_q   <= C_AXIS_H;
                    out_q    <= 4'b0000;
                end else begin
                    last_h_q <= last_h_d;
                    last_v_q <= last_v_d;
                    axis_q   <= axis_d;
                    out_q    <= out_d;
                end
            end

            assign outdir[4*p +: 4] = out_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_joy_socd_cond.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_joy_socd_cond                                        |
// | Desc   : Bench for joy_socd_cond, one instance without debounce  |
// |          and one with a 4-clock debounce, sharing all inputs.    |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_joy_socd_cond;

    localparam int P    = 2;
    localparam int NB   = 4 * P;
    localparam int DEBN = 4;

    logic          clk;
    logic          I_RESETn;
    logic [NB-1:0] indir;
    logic [1:0]    socd_mode;
    logic [P-1:0]  four_way;
    logic [NB-1:0] out0;
    logic [NB-1:0] out4;

    joy_socd_cond #(.PLAYERS(P), .DEB_CYCLES(0)) u_dut0 (
        .clk(clk), .I_RESETn(I_RESETn), .indir(indir),
        .socd_mode(socd_mode), .four_way(four_way), .outdir(out0)
    );

    joy_socd_cond #(.PLAYERS(P), .DEB_CYCLES(DEBN)) u_dut4 (
        .clk(clk), .I_RESETn(I_RESETn), .indir(indir),
        .socd_mode(socd_mode), .four_way(four_way), .outdir(out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: index 0 = no debounce, index 1 = DEBN debounce.
    // Press history is kept as the cycle number of each bit's latest press.
    logic [NB-1:0] m_s1, m_s2;
    logic [NB-1:0] m_deb [2];
    logic [NB-1:0] m_exp [2];
    logic [NB-1:0] m_win [$];
    int            m_ts  [2][NB];

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_deb[0] = '0;
        m_deb[1] = '0;
        m_win.delete();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < NB; b++) m_ts[m][b] = -1;
    endtask

    // Pair result {a,b}; a = L/U, b = R/D; ta/tb = latest press cycles
    function automatic logic [1:0] pair(input logic ha, input logic hb,
                                        input int ta, input int tb, input logic [1:0] mode);
        if (!(ha && hb)) return {ha, hb};
        if (mode == 2'b01 || mode == 2'b11) return 2'b00;
        if (ta < 0 && tb < 0) return 2'b00;
        if (ta == tb) return 2'b10;
        if (mode == 2'b00) return (ta > tb) ? 2'b10 : 2'b01;
        return (ta < tb) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [NB-1:0] model_out(input int m, input logic [1:0] mode,
                                               input logic [P-1:0] fw);
        logic [NB-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++) begin
            int b, th, tv;
            logic [1:0] h, v;
            b  = 4 * p;
            h  = pair(m_deb[m][b+1], m_deb[m][b],   m_ts[m][b+1], m_ts[m][b],   mode);
            v  = pair(m_deb[m][b+3], m_deb[m][b+2], m_ts[m][b+3], m_ts[m][b+2], mode);
            th = (m_ts[m][b+1] > m_ts[m][b])   ? m_ts[m][b+1] : m_ts[m][b];
            tv = (m_ts[m][b+3] > m_ts[m][b+2]) ? m_ts[m][b+3] : m_ts[m][b+2];
            if (fw[p] && (h != 2'b00) && (v != 2'b00))
                r[b +: 4] = (tv > th) ? {v, 2'b00} : {2'b00, h};
            else
                r[b +: 4] = {v, h};
        end
        return r;
    endfunction

    task automatic stamp(input int m, input logic [NB-1:0] pr);
        for (int b = 0; b < NB; b++) if (pr[b]) m_ts[m][b] = cyc;
    endtask

    // Advance one clock, update the model, then compare both outputs
    task automatic tick();
        logic [NB-1:0] prev;
        logic          dis;
        @(posedge clk);
        cyc++;
        m_exp[0] = model_out(0, socd_mode, four_way);
        m_exp[1] = model_out(1, socd_mode, four_way);
        prev     = m_deb[0];
        m_deb[0] = m_s1;
        stamp(0, m_deb[0] & ~prev);
        m_win.push_back(m_s2);
        if (m_win.size() > DEBN) void'(m_win.pop_front());
        prev = m_deb[1];
        if (m_win.size() == DEBN) begin
            for (int b = 0; b < NB; b++) begin
                dis = 1'b1;
                for (int k = 0; k < DEBN; k++) if (m_win[k][b] == prev[b]) dis = 1'b0;
                if (dis) m_deb[1][b] = ~prev[b];
            end
        end
        stamp(1, m_deb[1] & ~prev);
        m_s2 = m_s1;
        m_s1 = indir;
        #1;
        check("outdir_deb0_model", out0, m_exp[0]);
        check("outdir_deb4_model", out4, m_exp[1]);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear at once
    task automatic pulse_reset();
        #2;
        I_RESETn = 1'b0;
        #1;
        check("reset_async_deb0", out0, '0);
        check("reset_async_deb4", out4, '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        I_RESETn = 1'b1;
    endtask

    initial begin
        I_RESETn  = 1'b0;
        indir     = '0;
        socd_mode = 2'b00;
        four_way  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_deb0", out0, '0);
        check("reset_state_deb4", out4, '0);
        @(negedge clk);
        I_RESETn = 1'b1;
        settle(3);
        check("idle_after_reset", out0, '0);

        // Last-wins: R held, L pressed 5 clocks later, L released
        indir = 8'h01;
        settle(5);
        check("lw_r_alone", out0, 8'h01);
        indir = 8'h03;
        settle(2);
        check("lw_before_latency", out0, 8'h01);
        tick();
        check("lw_l_wins", out0, 8'h02);
        indir = 8'h01;
        settle(3);
        check("lw_l_released", out0, 8'h01);
        indir = 8'h00;
        settle(10);

        // Neutral with U+D, then switch to last-wins: tie goes to U
        socd_mode = 2'b01;
        indir     = 8'h0C;
        settle(8);
        check("neutral_ud_deb0", out0, 8'h00);
        check("neutral_ud_deb4", out4, 8'h00);
        socd_mode = 2'b00;
        tick();
        check("mode_switch_u_tie_deb0", out0, 8'h08);
        check("mode_switch_u_tie_deb4", out4, 8'h08);
        indir = 8'h00;
        settle(10);

        // First-wins: D held, U pressed, then D released
        socd_mode = 2'b10;
        indir     = 8'h04;
        settle(5);
        indir = 8'h0C;
        settle(3);
        check("fw_d_kept", out0, 8'h04);
        settle(2);
        check("fw_d_still_kept", out0, 8'h04);
        indir = 8'h08;
        settle(3);
        check("fw_d_released", out0, 8'h08);
        indir     = 8'h00;
        socd_mode = 2'b00;
        settle(10);

        // Debounce: a 3-clock glitch must not reach the output
        indir = 8'h01;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) indir = 8'h00;
            tick();
            check("deb4_glitch_blocked", out4, 8'h00);
        end
        // 6-clock pulse appears 7 clocks after its rising edge
        indir = 8'h01;
        settle(6);
        check("deb4_before_latency", out4, 8'h00);
        indir = 8'h00;
        tick();
        check("deb4_pulse_passes", out4, 8'h01);
        settle(10);

        // Four-way on player 1: R held then U pressed; player 0 idle
        four_way = 2'b10;
        indir    = 8'h10;
        settle(3);
        check("p1_r_alone", out0, 8'h10);
        settle(3);
        indir = 8'h90;
        settle(2);
        check("p1_before_latency", out0, 8'h10);
        tick();
        check("p1_fourway_u", out0, 8'h80);
        settle(5);
        check("p1_fourway_u_deb4", out4, 8'h80);
        four_way = 2'b00;
        tick();
        check("p1_diagonal_passes", out0, 8'h90);
        indir = 8'h00;
        settle(10);

        // Reset mid-debounce with R held throughout
        indir = 8'h01;
        settle(4);
        check("pre_reset_deb0", out0, 8'h01);
        check("pre_reset_deb4", out4, 8'h00);
        pulse_reset();
        settle(3);
        check("post_reset_press_deb0", out0, 8'h01);
        settle(3);
        check("post_reset_deb4_wait", out4, 8'h00);
        tick();
        check("post_reset_deb4_r", out4, 8'h01);

        // Random activity checked against the model every clock
        for (int i = 0; i < 900; i++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 7) == 0) indir[b] = ~indir[b];
            if ($urandom_range(0, 31) == 0) socd_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) four_way = P'($urandom_range(0, 3));
            if (i == 450) pulse_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joy_socd_cond.md
JOY_SOCD_COND -- requirements
Module: joy_socd_cond

Interface
REQ-001 Parameter PLAYERS, default 2, number of independent 4-direction channels (legal 1..4).
REQ-002 Parameter DEB_CYCLES, default 0, debounce stability length in clocks (legal 0..255; 0 = bypass).
REQ-003 clk  input  1  system clock; all state updates on its rising edge; one clock only.
REQ-004 I_RESETn  input  1  asynchronous, active-low reset.
REQ-005 indir  input  4*PLAYERS  raw active-high directions, asynchronous to clk; player p occupies bits [4p+3:4p], ordered {U,D,L,R} (bit 4p = R).
REQ-006 socd_mode  input  2  opposing-direction policy, shared by all players: 00 last-wins, 01 neutral, 10 first-wins, 11 neutral.
REQ-007 four_way  input  PLAYERS  per-player diagonal suppression enable.
REQ-008 outdir  output  4*PLAYERS  conditioned directions, same bit layout as indir, registered.

Function
REQ-009 Each indir bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-010 With DEB_CYCLES=0 the debounced value deb SHALL equal the synchroniser output combinationally.
REQ-011 With DEB_CYCLES=N>0, each bit SHALL own a counter: cleared when sync==deb; incremented when sync!=deb; deb<=sync and counter cleared on the Nth consecutive edge with sync!=deb.
REQ-012 A glitch shorter than N synchronised clocks SHALL not change deb.
REQ-013 A press event SHALL be deb rising (deb & ~deb_prev, deb_prev registered per bit).
REQ-014 Per player, SOCD SHALL be resolved independently on the horizontal pair {L,R} and the vertical pair {U,D}; a pair with zero or one bit held passes unchanged.
REQ-015 Last-wins (00): with both bits of a pair held, output SHALL be the member with the most recent press event; simultaneous press events on both members SHALL resolve to L (horizontal) and U (vertical).
REQ-016 Neutral (01, 11): with both bits of a pair held, output for that pair SHALL be 00.
REQ-017 First-wins (10): with both bits of a pair held, output SHALL be the member that was already held before the other was pressed; simultaneous presses SHALL resolve to L and U.
REQ-018 Per-pair history (last_h, last_v; 2 bits each, 00 = none) SHALL update on every press event regardless of current socd_mode; a mode change SHALL take effect on the next clock edge without clearing history.
REQ-019 If a pair is held with history 00 under modes 00/10, output for that pair SHALL be 00.
REQ-020 four_way[p]=1: if the SOCD-resolved result has a horizontal and a vertical bit both set, only the axis of the most recent press event (axis register, H or V) SHALL be output; simultaneous H and V presses SHALL select H; axis register resets to H.
REQ-021 four_way[p]=0: resolved result SHALL pass unchanged, and the axis register SHALL still track press events.
REQ-022 outdir SHALL be registered once after resolution; latency indir edge to outdir = 3 clocks for DEB_CYCLES=0, N+3 clocks for DEB_CYCLES=N.
REQ-023 Players SHALL be fully independent; activity on one player SHALL never alter another's output or state.

Reset
REQ-024 I_RESETn low SHALL asynchronously clear synchronisers, deb, deb_prev, debounce counters, last_h, last_v and outdir to 0, and set axis registers to H.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release the full N-clock stability requirement applies again.
REQ-026 Inputs held through reset release SHALL appear as press events on the first post-reset deb update.

Verification
REQ-027 DEB=0, mode 00, P0: R held, then L pressed 5 clocks later -> outdir[3:0] 0001 then 0010 three clocks after L edge; release L -> 0001.
REQ-028 DEB=0, mode 01: U and D both held -> outdir[3:0]=0000; switch to mode 00 -> 1000 (U, simultaneous rule) on next edge.
REQ-029 DEB=0, mode 10: D held, then U pressed -> outdir[3:0] stays 0100; release D -> 1000.
REQ-030 DEB=4: 3-clock pulse on R -> outdir unchanged 0; 6-clock pulse -> outdir R set 7 clocks after rising edge.
REQ-031 four_way[1]=1, PLAYERS=2: P1 R held, then U pressed -> outdir[7:4] 0001 -> 1000; P0 inputs idle give outdir[3:0]=0000 throughout.
REQ-032 I_RESETn pulsed low while R held mid-debounce (DEB=4) -> outdir=0 immediately; R appears 7 clocks after release.
